// File: rtl/lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_writer
// Purpose  : Holds a 2x16 character frame buffer written by the host and
//            streams the whole frame to the LCD controller FSM whenever the
//            buffer is dirty. A frame is sent as: line-0 address command,
//            16 line-0 characters, line-1 address command, then 16 line-1
//            characters. Each byte uses one data_ready / busy handshake.
// Ports    :
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   wr_en_i        host buffer write strobe
//   wr_addr_i[4:0] buffer address (0-15 line 0, 16-31 line 1)
//   wr_char_i[7:0] character code to store
//   lcd_busy_i     busy flag from the LCD controller
//   data_ready_o   one-cycle transfer request to the controller
//   d_out_o[7:0]   byte presented to the controller
//   rs_out_o       0 = command, 1 = character
//   refreshing_o   high while a frame transfer is in progress
//   frame_done_o   one-cycle pulse after the last transfer of a frame
// Revision : 1.0 - initial release
// ============================================================================
module lcd_text_writer #(
  parameter int         ACK_TIMEOUT = 64,
  parameter logic [7:0] LINE1_CMD   = 8'h80,
  parameter logic [7:0] LINE2_CMD   = 8'hC0,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [4:0] wr_addr_i,
  input  logic [7:0] wr_char_i,
  input  logic       lcd_busy_i,
  output logic       data_ready_o,
  output logic [7:0] d_out_o,
  output logic       rs_out_o,
  output logic       refreshing_o,
  output logic       frame_done_o
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [5:0]       LAST_IDX = 6'd33;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dirty_q, dirty_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             rs_q, rs_d;
  logic             refr_q, refr_d;
  logic             fdone_q, fdone_d;
  logic [7:0]       fb_q [32];

  logic [7:0]       load_byte;
  logic             load_rs;

  // Frame buffer: host writes are accepted in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) fb_q[i] <= BLANK_CHAR;
    end else if (wr_en_i) begin
      fb_q[wr_addr_i] <= wr_char_i;
    end
  end

  // Transfer index to byte mapping: commands sit at idx 0 and 17, so the
  // buffer offset is idx-1 on line 0 and idx-2 on line 1.
  always_comb begin
    load_byte = LINE1_CMD;
    load_rs   = 1'b0;
    if (idx_q == 6'd0) begin
      load_byte = LINE1_CMD;
    end else if (idx_q <= 6'd16) begin
      load_byte = fb_q[5'(idx_q - 6'd1)];
      load_rs   = 1'b1;
    end else if (idx_q == 6'd17) begin
      load_byte = LINE2_CMD;
    end else begin
      load_byte = fb_q[5'(idx_q - 6'd2)];
      load_rs   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= '0;
      dirty_q <= 1'b1;
      d_out_q <= 8'h00;
      rs_q    <= 1'b0;
      refr_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      d_out_q <= d_out_d;
      rs_q    <= rs_d;
      refr_q  <= refr_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    dirty_d      = dirty_q;
    d_out_d      = d_out_q;
    rs_d         = rs_q;
    refr_d       = refr_q;
    fdone_d      = 1'b0;
    data_ready_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dirty_q && !lcd_busy_i) begin
          dirty_d = 1'b0;
          idx_d   = 6'd0;
          refr_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      // d_out/rs_out are frozen here for the whole handshake because the
      // controller reads d_in combinationally while it works.
      S_LOAD: begin
        d_out_d = load_byte;
        rs_d    = load_rs;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!lcd_busy_i) begin
          data_ready_o = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT_ACK;
        end
      end
      // No busy response within the timeout: re-issue the same byte.
      S_WAIT_ACK: begin
        if (lcd_busy_i) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_LAST) state_d = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (!lcd_busy_i) begin
          if (idx_q == LAST_IDX) begin
            fdone_d = 1'b1;
            refr_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A write in the same cycle as the IDLE launch keeps the buffer dirty,
    // so the newer contents follow in another frame.
    if (wr_en_i) dirty_d = 1'b1;
  end

  assign d_out_o      = d_out_q;
  assign rs_out_o     = rs_q;
  assign refreshing_o = refr_q;
  assign frame_done_o = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_writer
// Purpose  : Self-checking bench for lcd_text_writer with a behavioural LCD
//            controller model and a reference frame-buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_text_writer;

  typedef byte unsigned fb_t [32];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_char = 8'd0;
  logic       lcd_busy = 1'b0;
  logic       data_ready;
  logic [7:0] d_out;
  logic       rs_out;
  logic       refreshing;
  logic       frame_done;

  lcd_text_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_char_i    (wr_char),
    .lcd_busy_i   (lcd_busy),
    .data_ready_o (data_ready),
    .d_out_o      (d_out),
    .rs_out_o     (rs_out),
    .refreshing_o (refreshing),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  fb_t        ref_fb;
  logic [8:0] xfer_log [$];
  int         dr_cyc   [$];
  logic [8:0] dr_val   [$];
  int         dr_count = 0;
  int         fd_count = 0;

  int init_left   = 200;
  int busy_left   = 0;
  bit pend        = 1'b0;
  bit hold        = 1'b0;
  bit ignore_next = 1'b0;

  always @(posedge clk) cyc++;

  // Controller model: sees a request, raises busy one cycle later for a
  // random transfer time, and can be told to ignore one request or to
  // hold busy high indefinitely.
  always @(negedge clk) begin
    bit dr;
    dr = data_ready;
    if (frame_done) fd_count++;
    if (!rst_n) begin
      pend      = 1'b0;
      busy_left = 0;
      lcd_busy  = 1'b0;
    end else begin
      if (init_left > 0) begin
        init_left--;
        lcd_busy = 1'b1;
      end else if (hold) begin
        lcd_busy = 1'b1;
      end else if (pend) begin
        pend      = 1'b0;
        busy_left = $urandom_range(100, 20) - 1;
        lcd_busy  = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        lcd_busy = 1'b1;
      end else begin
        lcd_busy = 1'b0;
      end
      if (dr) begin
        dr_count++;
        dr_cyc.push_back(cyc);
        dr_val.push_back({rs_out, d_out});
        if (ignore_next) ignore_next = 1'b0;
        else begin
          xfer_log.push_back({rs_out, d_out});
          pend = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] c);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_char = c;
    ref_fb[a] = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_fd(input int target, input string tag);
    int t = 0;
    while (fd_count < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(fd_count >= target), 32'd1);
  endtask

  task automatic wait_log(input int n, input string tag);
    int t = 0;
    while (xfer_log.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(xfer_log.size() >= n), 32'd1);
  endtask

  // Expected frame: address command, line 0, address command, line 1.
  task automatic check_frame(input int base, input fb_t fb, input string tag);
    logic [8:0] exp [$];
    exp.push_back(9'h080);
    for (int c = 0; c < 16; c++) exp.push_back({1'b1, fb[c]});
    exp.push_back(9'h0C0);
    for (int c = 16; c < 32; c++) exp.push_back({1'b1, fb[c]});
    check({tag, "_len"}, 32'(xfer_log.size() >= base + 34), 32'd1);
    if (xfer_log.size() >= base + 34) begin
      for (int i = 0; i < 34; i++)
        check($sformatf("%s_idx%0d", tag, i), 32'(xfer_log[base + i]), 32'(exp[i]));
    end
  endtask

  task automatic hold_check(input string tag);
    int         dc;
    logic [7:0] d0;
    int         ls;
    dc = dr_count;
    d0 = d_out;
    ls = xfer_log.size();
    repeat (120) @(negedge clk);
    check({tag, "_no_dr"}, 32'(dr_count), 32'(dc));
    check({tag, "_dout_stable"}, 32'(d_out), 32'(d0));
    check({tag, "_no_advance"}, 32'(xfer_log.size()), 32'(ls));
  endtask

  initial begin
    int   base;
    int   fdt;
    int   dcb;
    int   dqb;
    fb_t  snap;

    for (int i = 0; i < 32; i++) ref_fb[i] = 8'h20;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_d_out", 32'(d_out), 32'h00);
    check("rst_rs_out", 32'(rs_out), 32'd0);
    check("rst_refreshing", 32'(refreshing), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Controller initialisation: busy high, nothing requested
    repeat (150) @(negedge clk);
    check("init_no_dr", 32'(dr_count), 32'd0);
    check("init_not_refreshing", 32'(refreshing), 32'd0);

    // Blank frame after reset
    wait_log(1, "f0_started");
    check("f0_refreshing", 32'(refreshing), 32'd1);
    wait_fd(1, "f0_done");
    check_frame(0, ref_fb, "f0");
    check("f0_refreshing_low", 32'(refreshing), 32'd0);
    repeat (20) @(negedge clk);
    check("f0_single_pulse", 32'(fd_count), 32'd1);
    check("f0_no_new_frame", 32'(xfer_log.size()), 32'd34);
    fdt = 1;

    // Two characters written while busy held; then IDLE hold check
    hold = 1'b1;
    @(negedge clk);
    host_write(5'd0, 8'h48);
    host_write(5'd17, 8'h69);
    hold_check("idle_hold");
    hold = 1'b0;
    base = xfer_log.size();
    fdt++;
    wait_fd(fdt, "f1_done");
    check_frame(base, ref_fb, "f1");
    check("f1_H", 32'(xfer_log[base + 1]), 32'h148);
    check("f1_i", 32'(xfer_log[base + 19]), 32'h169);

    // Random write bursts
    for (int r = 0; r < 3; r++) begin
      int n;
      hold = 1'b1;
      @(negedge clk);
      n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++)
        host_write(5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
      hold = 1'b0;
      base = xfer_log.size();
      fdt++;
      wait_fd(fdt, $sformatf("rnd%0d_done", r));
      check_frame(base, ref_fb, $sformatf("rnd%0d", r));
    end

    // Write to the address being sent, plus a mid-frame busy hold
    hold = 1'b1;
    @(negedge clk);
    host_write(5'($urandom_range(31, 5)), 8'($urandom_range(255, 0)));
    snap = ref_fb;
    hold = 1'b0;
    base = xfer_log.size();
    wait_log(base + 6, "mid_reach_idx5");
    check("mid_refreshing", 32'(refreshing), 32'd1);
    host_write(5'd4, 8'h41);
    hold = 1'b1;
    hold_check("mid_hold");
    hold = 1'b0;
    fdt++;
    wait_fd(fdt, "mid_f1_done");
    check_frame(base, snap, "mid_f1");
    check("mid_f1_idx5_old", 32'(xfer_log[base + 5]), 32'({1'b1, snap[4]}));
    fdt++;
    wait_fd(fdt, "mid_f2_done");
    check_frame(base + 34, ref_fb, "mid_f2");
    check("mid_f2_idx5_new", 32'(xfer_log[base + 34 + 5]), 32'h141);

    // First request ignored: re-issue after the ack timeout
    hold = 1'b1;
    @(negedge clk);
    host_write(5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
    ignore_next = 1'b1;
    dcb  = dr_count;
    dqb  = dr_cyc.size();
    hold = 1'b0;
    base = xfer_log.size();
    fdt++;
    wait_fd(fdt, "to_done");
    check("to_dr_count", 32'(dr_count - dcb), 32'd35);
    if (dr_cyc.size() >= dqb + 2) begin
      check("to_gap", 32'(dr_cyc[dqb + 1] - dr_cyc[dqb]), 32'd64);
      check("to_same_byte", 32'(dr_val[dqb + 1]), 32'(dr_val[dqb]));
      check("to_first_byte", 32'(dr_val[dqb]), 32'h080);
    end else begin
      check("to_dr_logged", 32'(dr_cyc.size()), 32'(dqb + 2));
    end
    check_frame(base, ref_fb, "to");

    // Reset asserted at idx 20
    hold = 1'b1;
    @(negedge clk);
    host_write(5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
    hold = 1'b0;
    base = xfer_log.size();
    wait_log(base + 21, "rr_reach_idx20");
    #1 rst_n = 1'b0;
    #1;
    check("rr_data_ready", 32'(data_ready), 32'd0);
    check("rr_d_out", 32'(d_out), 32'h00);
    check("rr_rs_out", 32'(rs_out), 32'd0);
    check("rr_refreshing", 32'(refreshing), 32'd0);
    check("rr_frame_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 32; i++) ref_fb[i] = 8'h20;
    repeat (3) @(negedge clk);
    init_left = 50;
    rst_n = 1'b1;
    base = xfer_log.size();
    fdt++;
    wait_fd(fdt, "rr_done");
    check_frame(base, ref_fb, "rr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
